serial_fa_adder: RTL and testbench
==================================

// Module: serial_fa_adder
// PURPOSE
//  Bit-serial add controller that drives one full-adder cell (FA: a,b,cin -> sum,cout).
//  Operands are shifted through the FA LSB-first, one bit per clock; the carry is held in a flop between bits.
//  The block feeds the FA inputs, consumes its sum/cout, and collects a WIDTH-bit result for the FSM datapath.
// PARAMETERS
//  WIDTH    8    operand/result width in bits (>=2)
//  CNT_W    4    bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  a_in      in   WIDTH  operand A, captured on accepted start
//  b_in      in   WIDTH  operand B, captured on accepted start
//  cin_in    in   1      initial carry, captured on accepted start
//  fa_a      out  1      to FA a
//  fa_b      out  1      to FA b
//  fa_cin    out  1      to FA cin
//  fa_sum    in   1      from FA sum
//  fa_cout   in   1      from FA cout
//  busy      out  1      high in RUN
//  done      out  1      one-cycle pulse in DONE
//  sum_out   out  WIDTH  result, stable from DONE until next accepted start
//  cout_out  out  1      final carry, same validity as sum_out
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; a_sh, b_sh, sum_sh, sum_out = 0; carry_q, cout_out, busy, done = 0; cnt=0.
//  States: IDLE -> RUN -> DONE -> IDLE. Encoding is free; illegal state recovers to IDLE.
//  IDLE: fa_a=fa_b=fa_cin=0. start=1 -> a_sh<=a_in, b_sh<=b_in, carry_q<=cin_in, cnt<=0, state<=RUN.
//  RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q (combinational from flops; FA is combinational).
//   Each edge: sum_sh<={fa_sum,sum_sh[WIDTH-1:1]}; a_sh,b_sh shift right (0 in); carry_q<=fa_cout; cnt<=cnt+1.
//   When cnt==WIDTH-1 at the edge: state<=DONE; sum_out<=final shifted sum; cout_out<=fa_cout.
//  DONE: done=1, busy=0, FA inputs 0; next edge -> IDLE unconditionally (start in DONE ignored).
//  Latency: start sampled at edge k -> busy high cycles k+1..k+WIDTH -> done high cycle k+WIDTH+1.
//  Throughput: one add per WIDTH+2 cycles (start may be asserted again in the IDLE cycle after DONE).
//  Arithmetic: {cout_out,sum_out} = a_in + b_in + cin_in, modulo 2**(WIDTH+1); no overflow flag.
//  Boundaries:
//   - start while busy or done: ignored; captured operands unchanged.
//   - a_in/b_in/cin_in changes after acceptance: no effect.
//   - rst mid-RUN: abort, all state/outputs to reset values; no done pulse.
//   - rst and start same edge: rst wins.
//   - sum_out/cout_out not updated during RUN; previous result held until DONE.
// CONFIGURATION
//  SERIAL_SUB_EN defined: extra input port sub (1 bit), captured on accepted start with operands.
//   sub=1 -> b_sh<=~b_in and carry_q<=1 (cin_in ignored); result = a_in - b_in, cout_out=1 means no borrow.
//   sub=0 -> identical to add behaviour.
//  SERIAL_SUB_EN undefined: no sub port; add only.
// TESTING (bench uses a behavioural FA model or the transistor FA cell; WIDTH=8)
//  1. a=8'h5A, b=8'h3C, cin=0, start 1 cycle -> done at start+9, sum_out=8'h96, cout_out=0.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout_out=1; busy high exactly 8 cycles.
//  3. a=8'h00, b=8'h00, cin=1 -> sum_out=8'h01, cout_out=0; previous result held during RUN.
//  4. start held high through RUN with new operands -> ignored; one done pulse; next add starts at IDLE.
//  5. rst asserted 3 cycles into RUN -> next cycle IDLE, busy=0, sum_out=0, cout_out=0, no done.
//  6. SERIAL_SUB_EN: a=8'd10, b=8'd3, sub=1 -> sum_out=8'd7, cout_out=1; a=3, b=10 -> 8'hF9, cout_out=0.

Source files
------------

// File: rtl/serial_fa_adder.sv
// Bit-serial add controller driving an external full-adder cell, LSB first, one bit per clock.
// Optional SERIAL_SUB_EN adds a 'sub' input that selects a - b (two's complement) instead of a + b.
module serial_fa_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0]   sum_out_q, sum_out_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, done_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_bit;
    logic               sub_sel;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FA operand drive: combinational from flops, forced low outside RUN
    always_comb begin
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        if (state_q == S_RUN) begin
            fa_a   = a_sh_q[0];
            fa_b   = b_sh_q[0];
            fa_cin = carry_q;
        end
    end

    // Datapath next values
    always_comb begin
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        sum_out_d = sum_out_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        cnt_d     = cnt_q;
        if (state_q == S_IDLE && start) begin
            a_sh_d  = a_in;
            b_sh_d  = sub_sel ? ~b_in : b_in;
            carry_d = sub_sel ? 1'b1 : cin_in;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            sum_sh_d = (sum_sh_q >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_cout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_bit) begin
                sum_out_d = sum_sh_d;
                cout_d    = fa_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            sum_out_q <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            sum_out_q <= sum_out_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            cnt_q     <= cnt_d;
            busy_q    <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum_out  = sum_out_q;
    assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_fa_adder.sv
// Bench for serial_fa_adder with a behavioural full-adder cell and a result scoreboard.
// Define SERIAL_SUB_EN on both files to exercise the subtract option.
module tb_serial_fa_adder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic             cin_in;
    logic             sub_in;
    logic             fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic             busy, done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] sb[$];
    logic [WIDTH:0] last_res;

    serial_fa_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
`ifdef SERIAL_SUB_EN
        .sub      (sub_in),
`endif
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_sum   (fa_sum),
        .fa_cout  (fa_cout),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
    );

    // Behavioural full adder
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One complete operation; optionally keep start high with scrambled operands during RUN
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input logic s, input bit hold, input bit chk_hold);
        logic [WIDTH:0] expv, got;
        int lat, bcyc;
        bit held;
        if (s) expv = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else   expv = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
        sb.push_back(expv);
        a_in = a; b_in = b; cin_in = c; sub_in = s; start = 1'b1;
        tick();
        if (hold) begin
            a_in = ~a; b_in = a ^ b ^ 8'h5A; cin_in = ~c; sub_in = ~s;
        end else begin
            start = 1'b0;
        end
        lat = 1; bcyc = 0; held = 1'b1;
        while (!done && lat < 30) begin
            if (busy) bcyc++;
            if ({cout_out, sum_out} !== last_res) held = 1'b0;
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd9);
        check("busy_cycles", 32'(bcyc), 32'd8);
        if (chk_hold) check("result_held_in_run", 32'(held), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("result", 32'({cout_out, sum_out}), 32'(got));
            last_res = got;
        end else begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end
        start = 1'b0;
        tick();
        check("done_pulse_end", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
        last_res = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_cout", 32'(cout_out), 32'd0);
        check("rst_fa_in", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        rst = 1'b0;
        tick();

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(8'hA7, 8'h6E, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);

        // Abort mid-RUN
        a_in = 8'h81; b_in = 8'h92; cin_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy_before", 32'(busy), 32'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum_out), 32'd0);
        check("abort_cout", 32'(cout_out), 32'd0);
        last_res = '0;
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (done || busy) saw_done = 1'b1;
                tick();
            end
            check("abort_no_done", 32'(saw_done), 32'd0);
        end

        // Reset and start on the same edge
        rst = 1'b1; start = 1'b1; a_in = 8'h11; b_in = 8'h22;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'd0);
        tick();
        check("rst_wins_idle", 32'(busy), 32'd0);

        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SERIAL_SUB_EN
        run_op(8'd10, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op(8'd3, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
